pc_sequencer: RTL
=================

// Module: pc_sequencer
//
// PURPOSE
//   Program-counter sequencer for the 9-bit CPU fetch stage.
//   Owns the PC register and the start/run/halt state machine.
//   Drives the 2-bit pointer into the PC lookup table, which returns a signed
//   8-bit offset or target. Uses that value to form the next PC for
//   sequential, relative-branch and absolute-jump flow.
//   Handshakes with instruction memory and counts retired instructions.
//
// PARAMETERS
//   PC_W      8     PC width; also width of the LUT return value
//   START_PC  0     PC loaded on start
//   CNT_W     16    width of the retired-instruction counter (saturating)
//
// PORTS
//   Clk          in   1      system clock; all state changes on rising edge
//   Reset_n      in   1      asynchronous, active-low reset
//   start        in   1      pulse: begin or restart execution (honoured in IDLE/DONE only)
//   fetch_ready  in   1      imem accepts/returns the instruction at pc this cycle
//   branch_en    in   1      decoded instruction is a branch/jump
//   branch_sel   in   2      LUT pointer requested by decoder
//   jump_abs     in   1      1: LUT value is an absolute target; 0: signed relative offset
//   cond_ok      in   1      branch condition true (decoder ties high for unconditional)
//   halt         in   1      decoded instruction is HALT
//   lut_dout     in   PC_W   signed value returned by the PC LUT for lut_ptr
//   lut_ptr      out  2      pointer to the PC LUT
//   pc           out  PC_W   current fetch address
//   fetch_valid  out  1      pc is a valid fetch request
//   running      out  1      state is RUN or FLUSH
//   done         out  1      high in DONE until the next start
//   retired      out  CNT_W  instructions retired since the last start
//
// BEHAVIOUR
//   Reset (async, Reset_n=0)
//     - state=IDLE, pc=0, retired=0.
//     - fetch_valid=0, running=0, done=0.
//     - Takes effect immediately, including mid-RUN or mid-FLUSH.
//   States: IDLE, RUN, FLUSH, DONE (encoded in the shared package).
//   IDLE
//     - start=1: pc<=START_PC, retired<=0, next state RUN.
//   RUN
//     - fetch_valid=1.
//     - Instruction retires when fetch_valid & fetch_ready. Otherwise pc,
//       state and retired all hold (stall, no limit).
//   lut_ptr (combinational)
//     - branch_sel when branch_en & cond_ok & ~halt; otherwise 2'b00.
//     - The LUT default entry returns +1 for 2'b00.
//   Next PC on retire (modulo 2^PC_W, no saturation)
//     - halt=1: pc holds; next state DONE; done=1 next cycle.
//       Halt has priority over branch.
//     - taken branch, jump_abs=1: pc <= lut_dout; next state FLUSH.
//     - taken branch, jump_abs=0: pc <= pc + sign-extended lut_dout;
//       next state FLUSH.
//     - otherwise: pc <= pc + lut_dout (ptr 00 gives +1); stay in RUN.
//     - Not-taken branch (branch_en & ~cond_ok) is sequential, no bubble.
//   Retired counter
//     - +1 on every retire, including the HALT instruction.
//     - Saturates at 2^CNT_W-1.
//   FLUSH
//     - Exactly one cycle: fetch_valid=0, pc holds at the branch target.
//     - Returns to RUN. Decoder inputs are ignored.
//   DONE
//     - done=1, fetch_valid=0, pc holds.
//     - start=1 behaves as in IDLE: restart at START_PC, retired cleared,
//       done drops the next cycle.
//   start is ignored in RUN and FLUSH.
//   Wrap-around: 8'hFF+1 -> 8'h00; pc=1 with offset -3 -> 8'hFE.
//
// STRUCTURE
//   - pc_seq_pkg:
//       - seq_state_t enum (IDLE=2'b00, RUN=2'b01, FLUSH=2'b10, DONE=2'b11)
//       - PTR_SEQ=2'b00 constant
//       - LUT pointer width constant (2)
//   - No sub-module. The PC LUT stays a separate instance wired externally
//     through lut_ptr/lut_dout.
//   - Bench instantiates both blocks together.
//
// TESTING
//   1. Reset_n low, then high; start=1 for one cycle with fetch_ready=1
//      -> pc 0,1,2,3 on successive cycles; retired 1,2,3.
//   2. At pc=5: branch_en=1, branch_sel=01, jump_abs=1, cond_ok=1
//      (LUT returns 8) -> pc=8; one cycle fetch_valid=0; then pc=9.
//   3. At pc=1: branch_sel=10, jump_abs=0 (LUT returns -3) -> pc=8'hFE,
//      FLUSH, then pc=8'hFF, then pc=8'h00 (wrap).
//   4. fetch_ready=0 for 3 cycles at pc=4 -> pc, retired and state hold.
//      Release -> pc=5.
//   5. Same cycle: halt=1, branch_en=1, cond_ok=1 -> pc holds, DONE,
//      done=1, retired incremented once. start -> pc=START_PC, done=0.
//   6. Reset_n low during FLUSH -> outputs reset immediately, state IDLE.
//      Also: branch_en=1, cond_ok=0 -> lut_ptr=00, pc+1, no bubble.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer and its LUT wiring.
package pc_seq_pkg;

    localparam int unsigned PTR_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10,
        DONE  = 2'b11
    } seq_state_t;

    // LUT entry holding the sequential +1 step
    localparam logic [PTR_W-1:0] PTR_SEQ = 2'b00;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns PC, start/run/halt FSM, LUT pointer and retire counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned START_PC = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic             fetch_ready,
    input  logic             branch_en,
    input  logic [PTR_W-1:0] branch_sel,
    input  logic             jump_abs,
    input  logic             cond_ok,
    input  logic             halt,
    input  logic [PC_W-1:0]  lut_dout,
    output logic [PTR_W-1:0] lut_ptr,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_valid,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] retired
);

    localparam logic [PC_W-1:0]  START_VAL = PC_W'(START_PC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    seq_state_t       state;
    seq_state_t       state_next;
    logic [PC_W-1:0]  pc_next;
    logic [CNT_W-1:0] retired_next;
    logic             taken_c;

    // Taken-branch decode and LUT pointer; halt suppresses the branch
    always_comb begin
        taken_c = branch_en & cond_ok & ~halt;
        lut_ptr = taken_c ? branch_sel : PTR_SEQ;
    end

    // Next-state, next-PC and retire-count logic
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        retired_next = retired;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    pc_next      = START_VAL;
                    retired_next = '0;
                    state_next   = RUN;
                end
            end
            RUN: begin
                // fetch_valid is always high in RUN, so fetch_ready alone marks a retire
                if (fetch_ready) begin
                    retired_next = (retired == CNT_MAX) ? retired : retired + CNT_W'(1);
                    if (halt) begin
                        state_next = DONE;
                    end else if (taken_c) begin
                        // LUT value is already PC_W wide, so a plain modulo add is the signed offset
                        pc_next    = jump_abs ? lut_dout : pc + lut_dout;
                        state_next = FLUSH;
                    end else begin
                        pc_next = pc + lut_dout;
                    end
                end
            end
            FLUSH: begin
                state_next = RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, PC, counter and registered status flags
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            pc          <= '0;
            retired     <= '0;
            fetch_valid <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            retired     <= retired_next;
            fetch_valid <= (state_next == RUN);
            running     <= (state_next == RUN) || (state_next == FLUSH);
            done        <= (state_next == DONE);
        end
    end

endmodule
